// File: rtl/bitrev_pkg.sv
// Shared types and helpers for the ping-pong bit-reversal buffer.
// Holds the bank state encoding, the default frame-size limit and the k-bit reversal.
package bitrev_pkg;

    localparam int KMAX_DEF = 10;
    localparam int BR_W     = 32;
    localparam int BR_IW    = 5;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } bank_state_e;

    // Reverses the low k bits of x; bits at and above k come out as zero.
    function automatic logic [BR_W-1:0] bit_reverse(input logic [BR_W-1:0] x, input int k);
        logic [BR_W-1:0] r;
        r = '0;
        for (int i = 0; i < BR_W; i++) begin
            if (i < k) r[i] = x[BR_IW'(k - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/bitrev_pp_if.sv
// Write-side and read-side streaming handshake of the bit-reversal buffer.
// The slave modport is the buffer's view; the master modport is the producer/consumer view.
interface bitrev_pp_if #(
    parameter int DW = 32
);
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          last_o;
    logic          ready_i;

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, last_o
    );

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, last_o
    );
endinterface

// File: rtl/bitrev_pp_ram.sv
// Simple dual-port storage (1 write, 1 synchronous read) for both banks.
// The read register doubles as the output data register and holds when not read.
module bitrev_pp_ram #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/bitrev_pp.sv
// Ping-pong frame buffer: fills one bank in natural order while draining the other,
// optionally in bit-reversed order, with per-bank frame size and mode.
module bitrev_pp
    import bitrev_pkg::*;
#(
    parameter int KMAX = KMAX_DEF,
    parameter int DW   = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [$clog2(KMAX+1)-1:0] cfg_k_i,
    input  logic                      cfg_rev_i,
    bitrev_pp_if.slave                bus
);
    localparam int KW = $clog2(KMAX + 1);
    localparam int AW = KMAX + 1;

    function automatic logic [KW-1:0] sanitize_k(input logic [KW-1:0] k);
        if (k == '0 || int'(k) > KMAX) return KW'(KMAX);
        return k;
    endfunction

    function automatic logic [KMAX-1:0] last_idx(input logic [KW-1:0] k);
        logic [KMAX-1:0] m;
        for (int i = 0; i < KMAX; i++) m[i] = (i < int'(k));
        return m;
    endfunction

    bank_state_e     st_q [2];
    bank_state_e     st_d [2];
    logic [KW-1:0]   k_q  [2];
    logic [KW-1:0]   k_d  [2];
    logic            rev_q[2];
    logic            rev_d[2];
    logic            wp_q, wp_d, rp_q, rp_d;
    logic [KMAX-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic            valid_q, valid_d, last_q, last_d;

    logic            wr_ready, wr_fire, issue, wr_last, rd_last;
    logic [KW-1:0]   cfg_k_eff, wr_k;
    logic [KMAX-1:0] rd_idx;

    // The frame size is taken from cfg on the opening write, from the bank afterwards.
    assign cfg_k_eff = sanitize_k(cfg_k_i);
    assign wr_k      = (st_q[wp_q] == FREE) ? cfg_k_eff : k_q[wp_q];
    assign wr_last   = (wr_cnt_q == last_idx(wr_k));
    assign rd_last   = (rd_cnt_q == last_idx(k_q[rp_q]));
    assign rd_idx    = rev_q[rp_q] ? KMAX'(bit_reverse(BR_W'(rd_cnt_q), int'(k_q[rp_q])))
                                   : rd_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < 2; b++) begin
                st_q[b]  <= FREE;
                k_q[b]   <= '0;
                rev_q[b] <= 1'b0;
            end
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            st_q     <= st_d;
            k_q      <= k_d;
            rev_q    <= rev_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    // Writer and reader never own the same bank at once, so their updates cannot collide.
    always_comb begin
        st_d     = st_q;
        k_d      = k_q;
        rev_d    = rev_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (wr_fire) begin
            if (st_q[wp_q] == FREE) begin
                st_d[wp_q]  = FILL;
                k_d[wp_q]   = cfg_k_eff;
                rev_d[wp_q] = cfg_rev_i;
            end
            if (wr_last) begin
                st_d[wp_q] = FULL;
                wr_cnt_d   = '0;
                wp_d       = ~wp_q;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
        if (issue) begin
            if (rd_last) begin
                st_d[rp_q] = FREE;
                rd_cnt_d   = '0;
                rp_d       = ~rp_q;
            end else begin
                st_d[rp_q] = DRAIN;
                rd_cnt_d   = rd_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        wr_ready = (st_q[wp_q] == FREE) || (st_q[wp_q] == FILL);
        wr_fire  = bus.valid_i && wr_ready;
        issue    = ((st_q[rp_q] == FULL) || (st_q[rp_q] == DRAIN)) && (!valid_q || bus.ready_i);
        valid_d  = valid_q;
        last_d   = last_q;
        if (issue) begin
            valid_d = 1'b1;
            last_d  = rd_last;
        end else if (bus.ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    bitrev_pp_ram #(.AW(AW), .DW(DW)) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (wr_fire),
        .waddr_i ({wp_q, wr_cnt_q}),
        .wdata_i (bus.data_i),
        .re_i    (issue),
        .raddr_i ({rp_q, rd_idx}),
        .rdata_o (bus.data_o)
    );

    assign bus.ready_o = wr_ready;
    assign bus.valid_o = valid_q;
    assign bus.last_o  = last_q;
endmodule
